// File: rtl/bus_pkg.sv
// Shared definitions for the request/acknowledge bus slave.
//   - slave_state_e : FSM states of the slave
//   - addr_decode_e : result of decoding a latched transfer address
//   - RW_READ/RW_WRITE : encodings of the rw pin
//   - ADDR_WIDTH_DEF/DW_DEF : default bus widths
package bus_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DW_DEF         = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DRAIN
  } slave_state_e;

  typedef enum logic [1:0] {
    DEC_MEM,
    DEC_CNT,
    DEC_ERR
  } addr_decode_e;

endpackage

// File: rtl/slave_dut_if.sv
// Pin-level request/acknowledge bus between master_dut and slave_dut.
//   address/wr_data/rw/req : driven by the master
//   rd_data/ack/err/busy   : driven by the slave
interface slave_dut_if
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DW         = DW_DEF
);

  logic [ADDR_WIDTH-1:0] address;
  logic [DW-1:0]         wr_data;
  logic                  rw;
  logic                  req;
  logic [DW-1:0]         rd_data;
  logic                  ack;
  logic                  err;
  logic                  busy;

  modport master (
    output address, wr_data, rw, req,
    input  rd_data, ack, err, busy
  );

  modport slave (
    input  address, wr_data, rw, req,
    output rd_data, ack, err, busy
  );

endinterface

// File: rtl/slave_mem.sv
// Single-port synchronous RAM, DEPTH x DW, with registered read.
//   clk   : clock, all activity on posedge
//   we    : write enable, writes wdata to addr
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : registered read data, mem[addr] as of the previous edge
// Contents are intentionally not reset.
module slave_mem
  import bus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int DW    = DW_DEF,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/slave_dut.sv
// Bus slave: local memory window plus a read-only transaction counter.
//   clk : bus clock
//   rst : asynchronous active-low reset
//   bus : slave modport of slave_dut_if
//         (address/wr_data/rw/req in, rd_data/ack/err/busy out)
// Each transfer is latched in IDLE, held for WAIT_CYCLES wait states,
// answered with a one-cycle ack or err pulse, then the slave waits in
// DRAIN until the master releases req.
module slave_dut
  import bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int                    DW          = DW_DEF,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] CNT_ADDR    = ADDR_WIDTH'(16'hFFF0),
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  slave_dut_if.slave  bus
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  slave_state_e          state;
  addr_decode_e          dec_q;
  addr_decode_e          dec_now;
  logic [ADDR_WIDTH-1:0] offset_now;
  logic [MEM_AW-1:0]     offset_q;
  logic [DW-1:0]         wdata_q;
  logic                  rw_q;
  logic [3:0]            wait_cnt;
  logic [DW-1:0]         txn_cnt;
  logic [DW-1:0]         rd_data_q;
  logic                  ack_q;
  logic                  err_q;

  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DW-1:0]         mem_rdata;

  // Classify the live bus address; only used at the IDLE accept edge.
  always_comb begin
    offset_now = bus.address - BASE_ADDR;
    if (bus.address == CNT_ADDR) begin
      dec_now = DEC_CNT;
    end else if ((bus.address >= BASE_ADDR) &&
                 (32'(offset_now) < 32'(MEM_DEPTH))) begin
      dec_now = DEC_MEM;
    end else begin
      dec_now = DEC_ERR;
    end
  end

  // In IDLE the RAM is addressed straight from the bus so its registered
  // read is already valid one edge after acceptance (needed when there
  // are no wait states); afterwards the latched offset takes over.
  assign mem_addr = (state == IDLE) ? offset_now[MEM_AW-1:0] : offset_q;
  assign mem_we   = (state == RESP) && (dec_q == DEC_MEM) && (rw_q == RW_WRITE);

  slave_mem #(
    .DEPTH (MEM_DEPTH),
    .DW    (DW),
    .AW    (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // Transfer FSM with registered ack/err/rd_data and the transaction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dec_q     <= DEC_ERR;
      offset_q  <= '0;
      wdata_q   <= '0;
      rw_q      <= RW_READ;
      wait_cnt  <= '0;
      txn_cnt   <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            dec_q    <= dec_now;
            offset_q <= offset_now[MEM_AW-1:0];
            wdata_q  <= bus.wr_data;
            rw_q     <= bus.rw;
            wait_cnt <= 4'(WAIT_CYCLES);
            state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= DRAIN;
          case (dec_q)
            DEC_MEM: begin
              ack_q   <= 1'b1;
              txn_cnt <= txn_cnt + DW'(1);
              if (rw_q == RW_READ) begin
                rd_data_q <= mem_rdata;
              end
            end
            DEC_CNT: begin
              // The counter is read-only; reads return the pre-increment value.
              if (rw_q == RW_READ) begin
                ack_q     <= 1'b1;
                rd_data_q <= txn_cnt;
                txn_cnt   <= txn_cnt + DW'(1);
              end else begin
                err_q <= 1'b1;
              end
            end
            default: begin
              err_q <= 1'b1;
            end
          endcase
        end
        DRAIN: begin
          if (!bus.req) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_slave_dut.sv
// Self-checking bench for slave_dut. Two instances share one clock:
//   dut0 : WAIT_CYCLES=2, main functional sequence and reset abort
//   dut1 : WAIT_CYCLES=0, last-word access and counter wrap
// Stimulus pushes the expected response into a per-instance queue; a
// negedge monitor pops and compares whenever ack or err is seen.
module tb_slave_dut;
  import bus_pkg::*;

  typedef struct packed {
    logic       is_err;
    logic       is_read;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;

  logic [15:0] t_addr [2];
  logic [7:0]  t_data [2];
  logic        t_rw   [2];
  logic        t_req  [2];

  logic [1:0]  ack_v;
  logic [1:0]  err_v;
  logic [1:0]  busy_v;
  logic [7:0]  rd_v0;
  logic [7:0]  rd_v1;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  last_rd [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  slave_dut_if #(.ADDR_WIDTH(16), .DW(8)) bus0 ();
  slave_dut_if #(.ADDR_WIDTH(16), .DW(8)) bus1 ();

  assign bus0.address = t_addr[0];
  assign bus0.wr_data = t_data[0];
  assign bus0.rw      = t_rw[0];
  assign bus0.req     = t_req[0];
  assign bus1.address = t_addr[1];
  assign bus1.wr_data = t_data[1];
  assign bus1.rw      = t_rw[1];
  assign bus1.req     = t_req[1];

  assign ack_v  = {bus1.ack, bus0.ack};
  assign err_v  = {bus1.err, bus0.err};
  assign busy_v = {bus1.busy, bus0.busy};
  assign rd_v0  = bus0.rd_data;
  assign rd_v1  = bus1.rd_data;

  slave_dut #(.WAIT_CYCLES(2)) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0.slave)
  );

  slave_dut #(.WAIT_CYCLES(0)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Pop the oldest expected response for one instance and compare.
  task automatic scoreResponse(input bit sel);
    exp_t       e;
    logic [7:0] d;
    d = sel ? rd_v1 : rd_v0;
    checkOutput("ack_err_exclusive", 32'(ack_v[sel] & err_v[sel]), 32'd0);
    if ((sel == 1'b0 && q0.size() == 0) || (sel == 1'b1 && q1.size() == 0)) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_response dut%0d ack=%0b err=%0b required=none",
               sel, ack_v[sel], err_v[sel]);
      return;
    end
    if (sel == 1'b0) e = q0.pop_front();
    else             e = q1.pop_front();
    checkOutput("resp_is_err", 32'(err_v[sel]), 32'(e.is_err));
    if (!e.is_err && e.is_read) begin
      checkOutput("rd_data", 32'(d), 32'(e.data));
      last_rd[sel] = e.data;
    end else begin
      checkOutput("rd_data_held", 32'(d), 32'(last_rd[sel]));
    end
  endtask

  always @(negedge clk) if (ack_v[0] | err_v[0]) scoreResponse(1'b0);
  always @(negedge clk) if (ack_v[1] | err_v[1]) scoreResponse(1'b1);

  // One complete transfer. mode: 0 normal, 1 scramble inputs after
  // acceptance, 2 drop req after acceptance. hold: extra cycles req stays
  // high after the response. Called and returns at a negedge.
  task automatic applyStimulus(input bit sel, input logic rw, input logic [15:0] addr,
                               input logic [7:0] data, input logic exp_err,
                               input logic [7:0] exp_data, input int mode, input int hold);
    exp_t e;
    int   n;
    bit   got;
    int   lat;
    lat       = sel ? 1 : 3;
    e.is_err  = exp_err;
    e.is_read = rw;
    e.data    = exp_data;
    if (sel == 1'b0) q0.push_back(e);
    else             q1.push_back(e);
    t_addr[sel] = addr;
    t_data[sel] = data;
    t_rw[sel]   = rw;
    t_req[sel]  = 1'b1;
    n   = 0;
    got = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (mode == 1) begin
      t_addr[sel] = ~addr;
      t_data[sel] = ~data;
      t_rw[sel]   = ~rw;
    end else if (mode == 2) begin
      t_req[sel] = 1'b0;
    end
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = ack_v[sel] | err_v[sel];
    end
    checkOutput("response_seen", 32'(got), 32'd1);
    checkOutput("latency", 32'(n), 32'(lat));
    checkOutput("busy_in_drain", 32'(busy_v[sel]), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("busy_while_held", 32'(busy_v[sel]), 32'd1);
      checkOutput("no_extra_response", 32'(ack_v[sel] | err_v[sel]), 32'd0);
    end
    t_req[sel] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_after_drop", 32'(busy_v[sel]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      t_addr[i]  = '0;
      t_data[i]  = '0;
      t_rw[i]    = RW_READ;
      t_req[i]   = 1'b0;
      last_rd[i] = '0;
    end

    #2 rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ack", 32'(ack_v[0]), 32'd0);
    checkOutput("reset_err", 32'(err_v[0]), 32'd0);
    checkOutput("reset_busy", 32'(busy_v[0]), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_v0), 32'd0);
    checkOutput("reset_busy1", 32'(busy_v[1]), 32'd0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    @(negedge clk);

    // dut0: write/read, illegal accesses, counter, hold, early req drop.
    applyStimulus(1'b0, RW_WRITE, 16'h0010, 8'hA5, 1'b0, 8'h00, 0, 0);
    applyStimulus(1'b0, RW_READ,  16'h0010, 8'h00, 1'b0, 8'hA5, 0, 0);
    applyStimulus(1'b0, RW_READ,  16'h0100, 8'h00, 1'b1, 8'h00, 0, 0);
    applyStimulus(1'b0, RW_WRITE, 16'hFFF0, 8'h77, 1'b1, 8'h00, 0, 0);
    applyStimulus(1'b0, RW_WRITE, 16'h0011, 8'h3C, 1'b0, 8'h00, 1, 0);
    applyStimulus(1'b0, RW_READ,  16'hFFF0, 8'h00, 1'b0, 8'h03, 0, 0);
    applyStimulus(1'b0, RW_READ,  16'hFFF0, 8'h00, 1'b0, 8'h04, 0, 0);
    applyStimulus(1'b0, RW_READ,  16'h0011, 8'h00, 1'b0, 8'h3C, 0, 4);
    applyStimulus(1'b0, RW_READ,  16'h0010, 8'h00, 1'b0, 8'hA5, 2, 0);
    applyStimulus(1'b0, RW_WRITE, 16'h0020, 8'h11, 1'b0, 8'h00, 0, 0);

    // dut0: reset during the wait states of a write to 0x0020.
    t_addr[0] = 16'h0020;
    t_data[0] = 8'h99;
    t_rw[0]   = RW_WRITE;
    t_req[0]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_in_wait", 32'(busy_v[0]), 32'd1);
    #2 rst0 = 1'b0;
    #1;
    checkOutput("abort_ack", 32'(ack_v[0]), 32'd0);
    checkOutput("abort_err", 32'(err_v[0]), 32'd0);
    checkOutput("abort_busy", 32'(busy_v[0]), 32'd0);
    checkOutput("abort_rd_data", 32'(rd_v0), 32'd0);
    last_rd[0] = 8'h00;
    t_req[0]   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, RW_READ,  16'h0020, 8'h00, 1'b0, 8'h11, 0, 0);
    applyStimulus(1'b0, RW_READ,  16'hFFF0, 8'h00, 1'b0, 8'h01, 0, 0);
    applyStimulus(1'b0, RW_READ,  16'hFFFF, 8'h00, 1'b1, 8'h00, 0, 0);

    // dut1 (no wait states): last word, then drive the counter through wrap.
    applyStimulus(1'b1, RW_WRITE, 16'h00FF, 8'h5A, 1'b0, 8'h00, 0, 0);
    applyStimulus(1'b1, RW_READ,  16'h00FF, 8'h00, 1'b0, 8'h5A, 0, 0);
    applyStimulus(1'b1, RW_READ,  16'h0100, 8'h00, 1'b1, 8'h00, 0, 0);
    for (int i = 0; i < 253; i++) begin
      applyStimulus(1'b1, RW_WRITE, 16'(i), 8'(i), 1'b0, 8'h00, 0, 0);
    end
    applyStimulus(1'b1, RW_READ,  16'hFFF0, 8'h00, 1'b0, 8'hFF, 0, 0);
    applyStimulus(1'b1, RW_READ,  16'hFFF0, 8'h00, 1'b0, 8'h00, 0, 0);
    applyStimulus(1'b1, RW_READ,  16'h0007, 8'h00, 1'b0, 8'h07, 0, 0);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty0", 32'(q0.size()), 32'd0);
    checkOutput("scoreboard_empty1", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slave_dut.md
Name: slave_dut

Overview:
- Bus slave on the pin-level request/acknowledge bus, directly downstream of master_dut; consumes the master's address/wr_data/rw/req and produces rd_data/ack/err.
- Contains a word-addressed local memory window plus a read-only transaction counter register.
- Inserts a fixed number of wait states per transfer and flags out-of-window or illegal accesses with err instead of ack.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DW, 8, data width.
- BASE_ADDR, 16'h0000, first address of the memory window.
- MEM_DEPTH, 256, number of DW-bit words in the window; valid addresses are BASE_ADDR to BASE_ADDR+MEM_DEPTH-1.
- CNT_ADDR, 16'hFFF0, address of the read-only transaction counter; must lie outside the window.
- WAIT_CYCLES, 2, wait states inserted before the response; range 0..15.

Ports:
- clk  input  1  bus clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- address  input  ADDR_WIDTH  transfer address, valid while req=1.
- wr_data  input  DW  write data, valid while req=1 and rw=0.
- rw  input  1  1=read, 0=write.
- req  input  1  transfer request, held by the master until it sees ack or err.
- rd_data  output  DW  read data, valid in the ack cycle of a read.
- ack  output  1  one-cycle pulse: transfer completed successfully.
- err  output  1  one-cycle pulse: transfer rejected.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; ack=0, err=0, rd_data=0, busy=0, txn counter=0. Memory contents are not reset and are undefined until written.
- Reset mid-transfer aborts immediately to IDLE. No memory write occurs unless the write edge already happened.
- FSM states: IDLE, WAIT, RESP, DRAIN.
- IDLE:
  - On a posedge with req=1, latch address, wr_data and rw.
  - Decode the latched address: in-window, CNT_ADDR, or illegal.
  - Load the wait counter with WAIT_CYCLES, then go to WAIT, or straight to RESP if WAIT_CYCLES=0.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
- RESP: ack or err is registered high for exactly one cycle, then go to DRAIN.
- Response latency: if req is sampled high at edge N, ack/err is high during the cycle after edge N+1+WAIT_CYCLES.
- Response rules:
  - In-window read: ack=1; rd_data=mem[address-BASE_ADDR].
  - In-window write: ack=1; memory written at the same edge that raises ack.
  - Read of CNT_ADDR: ack=1; rd_data = txn counter (low DW bits).
  - Write to CNT_ADDR: err=1; no state change.
  - Any other address: err=1; memory unchanged; rd_data keeps its previous value.
- rd_data holds its last value between reads; it is not cleared after ack.
- Txn counter:
  - Increments by 1 on every ack (not on err).
  - Width DW; wraps from 2^DW-1 to 0.
  - The value returned by a counter read is the pre-increment value.
- DRAIN: wait for req=0, then go to IDLE. A req held high after the response is never treated as a new transfer; the master must drop req for at least one cycle between transfers.
- Changes on address/wr_data/rw while in WAIT are ignored, because the values were latched in IDLE.
- req dropping during WAIT: the transfer still completes and the response is still issued.
- ack and err are never high together.

Decomposition:
- Shared package bus_pkg holds:
  - State enum slave_state_e {IDLE, WAIT, RESP, DRAIN}.
  - Constants RW_READ=1'b1 and RW_WRITE=1'b0.
  - Default ADDR_WIDTH/DW localparams.
  - An addr_decode_e enum {DEC_MEM, DEC_CNT, DEC_ERR}.
- Sub-module slave_mem: single-port synchronous RAM, MEM_DEPTH x DW, with write enable and registered read. The top-level FSM, decode, wait counter and txn counter stay in slave_dut.

Test Plan (BASE_ADDR=0, MEM_DEPTH=256, WAIT_CYCLES=2 unless stated):
- Write 0xA5 to 0x0010, then read 0x0010 -> ack each time 3 cycles after req sampled; rd_data=0xA5; err never high.
- Read 0x0100 (just outside the window) and write 0xFFF0 -> err one-cycle pulse each time, ack=0, rd_data unchanged, counter unchanged.
- Three acked transfers, then read 0xFFF0 -> rd_data=0x03; a second read returns 0x04.
- Master holds req high 4 cycles after ack -> exactly one ack, busy=1 until req drops, then IDLE; next req is accepted normally.
- Assert rst=0 asynchronously during WAIT of a write to 0x0020 -> ack/err/busy drop immediately; after release, reading 0x0020 returns its prior value, not the aborted data.
- WAIT_CYCLES=0 build: read of 0x00FF (last word) -> ack in the cycle after the req sample edge; 256 writes then 1 more acked read -> counter wraps from 0xFF to 0x00.
